// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PRESC_W = 8;

    localparam logic [DIGIT_W-1:0] MAX_UNITS = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_TENS  = 4'd5;

    localparam logic [4*DIGIT_W-1:0] TERMINAL_BCD = 16'h5959;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } bcd_time_t;

endpackage

// File: rtl/bcd_mod_counter.sv
// One BCD digit counting 0..max; carry flags the enabled rollover to the next digit.
module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    // Combinational carry so the whole digit chain ripples on a single edge.
    assign carry = en && (q == max);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= carry ? '0 : q + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control: clk_div edge detect, prescaler, run/pause/lap FSM and MM:SS display select.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_div,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    output logic [DIGIT_W-1:0] disp_d3,
    output logic [DIGIT_W-1:0] disp_d2,
    output logic [DIGIT_W-1:0] disp_d1,
    output logic [DIGIT_W-1:0] disp_d0,
    output logic               running,
    output logic               lap_active,
    output logic               wrap
);

    state_t              state, state_next;
    logic                q1, q2, tick, inc;
    logic                counting, clear_acc, snap_load;
    logic [PRESC_W-1:0]  presc;
    logic [3:0]          carry;
    logic [DIGIT_W-1:0]  c0, c1, c2, c3;
    bcd_time_t           live, snap;

    assign tick = q1 && !q2;
    assign inc  = tick && counting && (presc == PRESC_W'(PRESCALE - 1));
    assign live = {c3, c2, c1, c0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-cycle strobes derived from the current state.
    always_comb begin
        state_next = state;
        counting   = 1'b0;
        clear_acc  = 1'b0;
        snap_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_stop) state_next = ST_RUN;
            end
            ST_RUN: begin
                counting = 1'b1;
                if (start_stop) begin
                    state_next = ST_PAUSE;
                end else if (lap) begin
                    state_next = ST_LAP;
                    snap_load  = 1'b1;
                end
            end
            ST_LAP: begin
                counting = 1'b1;
                if (start_stop) state_next = ST_PAUSE;
                else if (lap)   state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    clear_acc  = 1'b1;
                end else if (start_stop) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q1         <= 1'b0;
            q2         <= 1'b0;
            presc      <= '0;
            snap       <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            q1         <= clk_div;
            q2         <= q1;
            running    <= (state_next == ST_RUN) || (state_next == ST_LAP);
            lap_active <= (state_next == ST_LAP);
            // Digit-3 carry only fires on an increment at the terminal value.
            wrap       <= carry[3] && (live == TERMINAL_BCD);
            if (clear_acc) begin
                presc <= '0;
            end else if (tick && counting) begin
                presc <= inc ? '0 : presc + PRESC_W'(1);
            end
            if (snap_load) begin
                snap <= live;
            end
        end
    end

    bcd_mod_counter u_d0 (.clk(clk), .reset(reset), .clr(clear_acc), .en(inc),
                          .max(MAX_UNITS), .q(c0), .carry(carry[0]));
    bcd_mod_counter u_d1 (.clk(clk), .reset(reset), .clr(clear_acc), .en(carry[0]),
                          .max(MAX_TENS),  .q(c1), .carry(carry[1]));
    bcd_mod_counter u_d2 (.clk(clk), .reset(reset), .clr(clear_acc), .en(carry[1]),
                          .max(MAX_UNITS), .q(c2), .carry(carry[2]));
    bcd_mod_counter u_d3 (.clk(clk), .reset(reset), .clr(clear_acc), .en(carry[2]),
                          .max(MAX_TENS),  .q(c3), .carry(carry[3]));

    // Snapshot is frozen on screen only while lapping.
    assign {disp_d3, disp_d2, disp_d1, disp_d0} = lap_active ? snap : live;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: vector table plus hand sequences for timing corners.
module tb_stopwatch_core;

    logic clk, reset, clk_div, start_stop, lap, clear;
    logic [3:0] d3, d2, d1, d0, e3, e2, e1, e0;
    logic running, lap_active, wrap, running4, lap_active4, wrap4;
    logic [15:0] disp, disp4;
    int n_tests, n_fail;

    assign disp  = {d3, d2, d1, d0};
    assign disp4 = {e3, e2, e1, e0};

    stopwatch_core #(.PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .clk_div(clk_div), .start_stop(start_stop),
        .lap(lap), .clear(clear), .disp_d3(d3), .disp_d2(d2), .disp_d1(d1),
        .disp_d0(d0), .running(running), .lap_active(lap_active), .wrap(wrap));

    stopwatch_core #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .clk_div(clk_div), .start_stop(start_stop),
        .lap(lap), .clear(clear), .disp_d3(e3), .disp_d2(e2), .disp_d1(e1),
        .disp_d0(e0), .running(running4), .lap_active(lap_active4), .wrap(wrap4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_tick;
        int          n;
        logic        ss, lp, cl;
        logic [15:0] exp_disp;
        logic        exp_run, exp_lap;
    } vec_t;

    function automatic vec_t mkv(input logic t, input int n, input logic ss, input logic lp,
                                 input logic cl, input logic [15:0] dsp, input logic r,
                                 input logic la);
        vec_t v;
        v.is_tick = t; v.n = n; v.ss = ss; v.lp = lp; v.cl = cl;
        v.exp_disp = dsp; v.exp_run = r; v.exp_lap = la;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        cyc();
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    // One clk_div period: two cycles high, two low.
    task automatic do_tick(input int n);
        for (int k = 0; k < n; k++) begin
            clk_div = 1'b1; cyc(); cyc();
            clk_div = 1'b0; cyc(); cyc();
        end
    endtask

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; clk_div = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

        vecs[0]  = mkv(0, 0, 0, 0, 0, 16'h0010, 1, 0);
        vecs[0]  = mkv(1, 9, 0, 0, 0, 16'h0010, 1, 0);
        vecs[1]  = mkv(0, 0, 0, 0, 1, 16'h0010, 1, 0);
        vecs[2]  = mkv(0, 0, 1, 0, 1, 16'h0010, 0, 0);
        vecs[3]  = mkv(1, 1, 0, 0, 0, 16'h0010, 0, 0);
        vecs[4]  = mkv(0, 0, 1, 0, 1, 16'h0000, 0, 0);
        vecs[5]  = mkv(0, 0, 1, 0, 0, 16'h0000, 1, 0);
        vecs[6]  = mkv(1, 5, 0, 0, 0, 16'h0005, 1, 0);
        vecs[7]  = mkv(0, 0, 0, 1, 0, 16'h0005, 1, 1);
        vecs[8]  = mkv(1, 3, 0, 0, 0, 16'h0005, 1, 1);
        vecs[9]  = mkv(0, 0, 0, 1, 0, 16'h0008, 1, 0);
        vecs[10] = mkv(0, 0, 1, 1, 0, 16'h0008, 0, 0);
        vecs[11] = mkv(0, 0, 0, 1, 0, 16'h0008, 0, 0);
        vecs[12] = mkv(0, 0, 1, 0, 0, 16'h0008, 1, 0);
        vecs[13] = mkv(0, 0, 0, 1, 0, 16'h0008, 1, 1);
        vecs[14] = mkv(1, 2, 0, 0, 0, 16'h0008, 1, 1);
        vecs[15] = mkv(0, 0, 1, 0, 1, 16'h0010, 0, 0);
        vecs[16] = mkv(0, 0, 0, 0, 1, 16'h0000, 0, 0);

        // Reset values and idle behaviour.
        cyc(); cyc();
        chk("reset disp", 32'(disp), 32'h0000);
        chk("reset running", 32'(running), 32'h0);
        chk("reset lap_active", 32'(lap_active), 32'h0);
        chk("reset wrap", 32'(wrap), 32'h0);
        reset = 1'b0;
        cmd(0, 1, 0); cmd(0, 0, 1); do_tick(1);
        chk("idle ignores lap/clear/tick", 32'(disp), 32'h0000);
        chk("idle running", 32'(running), 32'h0);

        // Increment lands on the second edge after clk_div is sampled high.
        cmd(1, 0, 0);
        chk("start running", 32'(running), 32'h1);
        clk_div = 1'b1; cyc();
        chk("first tick sample edge", 32'(disp), 32'h0000);
        cyc();
        chk("first tick count edge", 32'(disp), 32'h0001);
        clk_div = 1'b0; cyc(); cyc();

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_tick) do_tick(vecs[i].n);
            else cmd(vecs[i].ss, vecs[i].lp, vecs[i].cl);
            chk($sformatf("vec%0d disp", i), 32'(disp), 32'(vecs[i].exp_disp));
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].exp_run));
            chk($sformatf("vec%0d lap_active", i), 32'(lap_active), 32'(vecs[i].exp_lap));
        end

        // Lap on the increment edge snapshots the pre-increment count.
        cmd(1, 0, 0); do_tick(3);
        clk_div = 1'b1; cyc();
        lap = 1'b1; cyc(); lap = 1'b0;
        chk("lap same-edge snapshot", 32'(disp), 32'h0003);
        chk("lap same-edge lap_active", 32'(lap_active), 32'h1);
        clk_div = 1'b0; cyc(); cyc();
        cmd(0, 1, 0);
        chk("lap exit live", 32'(disp), 32'h0004);
        // Pause on the increment edge still counts.
        clk_div = 1'b1; cyc();
        start_stop = 1'b1; cyc(); start_stop = 1'b0;
        chk("pause same-edge inc", 32'(disp), 32'h0005);
        chk("pause same-edge running", 32'(running), 32'h0);
        clk_div = 1'b0; cyc(); cyc();
        cmd(0, 0, 1);
        chk("clear from pause", 32'(disp), 32'h0000);

        // Rollover through 59:59.
        cmd(1, 0, 0); do_tick(3598);
        chk("preload 59:58", 32'(disp), 32'h5958);
        do_tick(1);
        chk("at 59:59", 32'(disp), 32'h5959);
        chk("no wrap at 59:59", 32'(wrap), 32'h0);
        clk_div = 1'b1; cyc(); cyc();
        chk("wrap to 00:00", 32'(disp), 32'h0000);
        chk("wrap pulse", 32'(wrap), 32'h1);
        clk_div = 1'b0; cyc();
        chk("wrap one cycle", 32'(wrap), 32'h0);
        cyc();
        do_tick(1);
        chk("after wrap 00:01", 32'(disp), 32'h0001);

        // Reset while lapping at 12:34, clk_div held high across release.
        do_tick(753);
        cmd(0, 1, 0);
        chk("lap at 12:34", 32'(disp), 32'h1234);
        reset = 1'b1; clk_div = 1'b1; cyc();
        chk("reset in lap disp", 32'(disp), 32'h0000);
        chk("reset in lap running", 32'(running), 32'h0);
        chk("reset in lap lap_active", 32'(lap_active), 32'h0);
        chk("reset in lap wrap", 32'(wrap), 32'h0);
        reset = 1'b0; cyc(); cyc(); cyc();
        chk("release no increment", 32'(disp), 32'h0000);
        chk("release idle", 32'(running), 32'h0);
        clk_div = 1'b0; cyc(); cyc();

        // Prescaler of four, including a pause mid-prescale.
        cmd(1, 0, 0); do_tick(8);
        chk("p4 eight ticks", 32'(disp4), 32'h0002);
        chk("p1 eight ticks", 32'(disp), 32'h0008);
        do_tick(2);
        chk("p4 partial", 32'(disp4), 32'h0002);
        cmd(1, 0, 0);
        chk("p4 paused", 32'(running4), 32'h0);
        cmd(1, 0, 0);
        do_tick(1);
        chk("p4 resume one tick", 32'(disp4), 32'h0002);
        do_tick(1);
        chk("p4 resume two ticks", 32'(disp4), 32'h0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning the number of clk_div rising edges per count increment (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clk_div  input  1  divided square wave from the frequency divider, sampled as data and never used as a clock.
REQ-005 SHALL have port start_stop  input  1  single-cycle command pulse, already debounced.
REQ-006 SHALL have port lap  input  1  single-cycle command pulse, already debounced.
REQ-007 SHALL have port clear  input  1  single-cycle command pulse, already debounced.
REQ-008 SHALL have ports disp_d3, disp_d2, disp_d1, disp_d0  output  4 each  displayed BCD digits for MM:SS, with d3 as minutes tens.
REQ-009 SHALL have port running  output  1  high in RUN or LAP.
REQ-010 SHALL have port lap_active  output  1  high in LAP.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on rollover from 59:59 to 00:00.

Function
REQ-012 SHALL register clk_div into q1, then q1 into q2; tick = q1 AND NOT q2; tick is high for exactly one clk cycle per clk_div rising edge.
REQ-013 SHALL keep an 8-bit prescaler that advances on tick in RUN or LAP; on the tick where prescaler == PRESCALE-1, it SHALL reset to 0 and assert internal inc.
REQ-014 SHALL hold the prescaler in IDLE and PAUSE, and SHALL zero it on reset or on an accepted clear.
REQ-015 SHALL keep the live count as 4 BCD digits with these ranges: c0 0-9, c1 0-5, c2 0-9, c3 0-5; inc SHALL carry ripple-style within the same edge.
REQ-016 SHALL, on inc at 59:59, load 00:00 and assert wrap in the following cycle only; counting SHALL continue.
REQ-017 SHALL increment the count 1 clk edge after the cycle in which tick and inc are high; with PRESCALE=1, the count changes 2 clk edges after clk_div is first sampled high.
REQ-018 SHALL use FSM states IDLE, RUN, PAUSE, LAP.
REQ-019 SHALL implement IDLE transitions: start_stop -> RUN; all other commands ignored.
REQ-020 SHALL implement RUN transitions: start_stop -> PAUSE; lap -> LAP; clear ignored.
REQ-021 SHALL implement LAP transitions: lap -> RUN; start_stop -> PAUSE; clear ignored.
REQ-022 SHALL implement PAUSE transitions: start_stop -> RUN; clear -> IDLE with count and prescaler zeroed.
REQ-023 SHALL resolve simultaneous commands by priority clear > start_stop > lap; in RUN or LAP, clear is ignored and the next priority applies.
REQ-024 SHALL evaluate counting using the current state, so an inc in the same cycle as a RUN->PAUSE transition still takes effect.
REQ-025 SHALL, on RUN->LAP, latch a snapshot of the live count as it was before any same-cycle increment; the disp_* outputs SHALL show the snapshot while in LAP and the live count in every other state.
REQ-026 SHALL drive disp_* from registers only, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, on reset high at a clk edge, set state to IDLE, count, snapshot and prescaler to 0, q1 and q2 to 0, and disp_* = 0, running = 0, lap_active = 0, wrap = 0.
REQ-028 SHALL give reset priority over all commands and ticks; reset mid-count in any state SHALL give the values in REQ-027 on the next edge.
REQ-029 SHALL suppress a tick by the q2 = 0 reset value if clk_div is high immediately after reset release; the first tick then occurs one cycle after release.

Structure
REQ-030 SHALL place the FSM state encodings, digit limits (9, 5) and the 59:59 terminal value in the shared package stopwatch_pkg.
REQ-031 SHALL implement each digit in the sub-module bcd_mod_counter (ports: clk, reset, clr, en, max, q, carry), instantiated 4 times.
REQ-032 SHALL scope the design to between 120 and 400 lines of RTL in total.

Verification
REQ-033 Scenario: reset, then start_stop, then 10 clk_div periods with PRESCALE=1 -> display 00:10, running=1, and each increment 2 edges after clk_div is sampled high.
REQ-034 Scenario: preload by running to 59:58, then 2 ticks -> 59:59, then 00:00 with a 1-cycle wrap pulse; the following tick gives 00:01.
REQ-035 Scenario: at 00:05 in RUN, lap, then 3 ticks -> display holds 00:05 and lap_active=1; a second lap -> display 00:08.
REQ-036 Scenario: in RUN, start_stop and clear in the same cycle -> PAUSE with the count kept; in PAUSE, start_stop and clear together -> IDLE with display 00:00.
REQ-037 Scenario: PRESCALE=4, 8 clk_div periods -> display 00:02; pause after 2 ticks, resume, then 2 ticks -> exactly 1 additional increment.
REQ-038 Scenario: reset asserted at 12:34 in LAP -> next cycle state IDLE with all outputs 0; clk_div held high across release -> no increment.
